decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode / operand-fetch stage feeding the ALU. Accepts one 32-bit
//  RV32I word per cycle and decodes OP (0110011) and OP-IMM (0010011) only.
//  Holds the 32x32 register file and a pending-write scoreboard, and stalls on
//  RAW hazards. Issues registered x, y, funct3, funct7, alu_sel and rd to the ALU.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_AW      5   register address width; file depth is 2**REG_AW
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  instr_valid   in   1      instr holds a fetched word
//  instr         in   32     instruction word
//  instr_ready   out  1      stage accepts instr this cycle (combinational)
//  wb_en         in   1      writeback strobe from the result stage
//  wb_rd         in   REG_AW writeback destination register
//  wb_data       in   XLEN   writeback value
//  alu_valid     out  1      registered; issued operands are new this cycle
//  alu_x         out  XLEN   rs1 value
//  alu_y         out  XLEN   rs2 value (OP) or immediate (OP-IMM)
//  alu_funct3    out  3      instr[14:12]
//  alu_funct7    out  7      see BEHAVIOUR
//  alu_sel       out  1      1 = OP-IMM, 0 = OP
//  alu_rd        out  REG_AW destination register, travels with the result
//  illegal_instr out  1      one-cycle pulse on an accepted undecodable word
// BEHAVIOUR
//  - Reset: every output, every register-file entry and every scoreboard bit go to 0.
//    rst mid-stall drops the stalled word, and instr_ready is 1 on the first cycle after reset.
//  - Accept = instr_valid & instr_ready. Registered outputs update on the edge
//    after accept (1-cycle latency). With no accept, alu_valid=0 and the data outputs hold.
//  - Decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
//    OP-IMM: y = sign-extended instr[31:20], funct7 = 0. For funct3 001/101,
//    y = zero-extended instr[24:20] and funct7 = instr[31:25].
//    OP: y = R[rs2], funct7 = instr[31:25].
//  - Illegal: any other opcode; OP with funct7 not in {0000000, 0100000};
//    0100000 with OP funct3 other than 000/101; SLLI with funct7 != 0; SRLI/SRAI with
//    funct7 not in {0000000, 0100000}. Outcome: illegal_instr=1 for one cycle,
//    alu_valid=0, scoreboard unchanged, word consumed.
//  - Register file: 2 async read ports, 1 sync write port. x0 reads 0 and ignores writes.
//    Write-through bypass: wb_en & wb_rd==rsN & rsN!=0 returns wb_data in the same cycle.
//  - Scoreboard pend[31:1]: set on the edge that issues a legal word with rd!=0.
//    Cleared on the edge where wb_en & wb_rd==r. Set and clear on the same r in the same
//    cycle: set wins (the newer producer).
//  - Hazard: pend[rs1] (rs1!=0), or pend[rs2] for OP (rs2!=0), and that register is
//    not being written back this cycle. Hazard forces instr_ready=0.
//    instr_ready = !(instr_valid & hazard). Illegal words never stall.
//  - FSM {RUN, STALL}: RUN->STALL when instr_valid & hazard.
//    STALL->RUN when hazard clears, issuing on that same cycle's edge.
//    STALL->RUN also when instr_valid drops. STALL is informational only; ready stays combinational.
//  - Upstream must hold instr stable while instr_valid & !instr_ready.
// STRUCTURE
//  - defines.v gains OPCODE_OP, OPCODE_OP_IMM and FUNCT7_ALT (0100000), alongside
//    the existing FUNCT3_*/FUNCT7_* constants, which this block reuses.
//  - Sub-module reg_file: 2R1W with x0 hardwiring and write-through bypass.
//    Decode, scoreboard and FSM live in decode_stage.
// TESTING
//  1. rst=1 mid-stall -> all outputs 0, pend all 0, instr_ready=1 next cycle.
//  2. ADDI x1,x0,-5 (0xFFB00093) -> next cycle: alu_valid=1, x=0, y=0xFFFFFFFB,
//     alu_sel=1, rd=1, pend[1]=1.
//  3. After case 2, ADD x2,x1,x1 with no writeback -> ready=0, alu_valid=0.
//     Then wb_en, rd=1, data=7 -> accepted that cycle; next cycle x=y=7, funct7=0.
//  4. SRAI x3,x4,3 (0x40325193) -> y=3, funct7=0x20, funct3=101. SLLI with funct7=0x20
//     -> illegal_instr=1, alu_valid=0.
//  5. wb_en to x0 with data 0xDEAD -> reading x0 returns 0. Issue to rd=5 in the same
//     cycle as wb_rd=5 -> pend[5] stays 1.
//  6. Opcode 0x03 (LOAD) -> illegal_instr one-cycle pulse, no stall, pend unchanged.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared opcode/funct constants, FSM state type and default widths for the decode stage.
package decode_stage_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file; x0 reads zero, and a same-cycle writeback is bypassed to the readers.
module decode_stage_reg_file #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [XLEN-1:0]   rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch for RV32I OP and OP-IMM: scoreboarded RAW stall, registered issue to the ALU.
//   state    | meaning
//   ST_RUN   | no word is being held back
//   ST_STALL | a valid word is waiting on a pending source register
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              alu_valid,
    output logic [XLEN-1:0]   alu_x,
    output logic [XLEN-1:0]   alu_y,
    output logic [2:0]        alu_funct3,
    output logic [6:0]        alu_funct7,
    output logic              alu_sel,
    output logic [REG_AW-1:0] alu_rd,
    output logic              illegal_instr
);

    localparam int NREG = 2 ** REG_AW;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;

    assign opcode = instr[6:0];
    assign rd     = instr[7 +: REG_AW];
    assign funct3 = instr[14:12];
    assign rs1    = instr[15 +: REG_AW];
    assign rs2    = instr[20 +: REG_AW];
    assign funct7 = instr[31:25];

    logic            legal;
    logic            is_op;
    logic [6:0]      funct7_issue;
    logic [XLEN-1:0] imm;

    always_comb begin
        legal        = 1'b0;
        is_op        = 1'b0;
        funct7_issue = FUNCT7_ZERO;
        imm          = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (opcode)
            OPCODE_OP: begin
                is_op        = 1'b1;
                funct7_issue = funct7;
                legal        = (funct7 == FUNCT7_ZERO) ||
                               ((funct7 == FUNCT7_ALT) &&
                                ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA)));
            end
            OPCODE_OP_IMM: begin
                if ((funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL_SRA)) begin
                    // Shifts carry a 5-bit shamt; the upper bits are the funct7 selector.
                    imm          = {{(XLEN-5){1'b0}}, instr[24:20]};
                    funct7_issue = funct7;
                    legal        = (funct7 == FUNCT7_ZERO) ||
                                   ((funct3 == FUNCT3_SRL_SRA) && (funct7 == FUNCT7_ALT));
                end else begin
                    legal = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    decode_stage_reg_file #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_data),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_data),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic            dep1;
    logic            dep2;
    logic            hazard;
    logic            accept;
    logic            issue;

    // A source being written back this cycle is served by the bypass, so it does not stall.
    assign dep1   = (rs1 != '0) && pend[rs1] && !(wb_en && (wb_rd == rs1));
    assign dep2   = is_op && (rs2 != '0) && pend[rs2] && !(wb_en && (wb_rd == rs2));
    assign hazard = legal && (dep1 || dep2);

    assign instr_ready = !(instr_valid && hazard);
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && legal;

    always_comb begin
        pend_next = pend;
        if (wb_en) begin
            pend_next[wb_rd] = 1'b0;
        end
        if (issue && (rd != '0)) begin
            pend_next[rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (instr_valid && hazard) state_next = ST_STALL;
            ST_STALL: if (!instr_valid || !hazard) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid     <= 1'b0;
            illegal_instr <= 1'b0;
            alu_x         <= '0;
            alu_y         <= '0;
            alu_funct3    <= '0;
            alu_funct7    <= '0;
            alu_sel       <= 1'b0;
            alu_rd        <= '0;
        end else begin
            alu_valid     <= issue;
            illegal_instr <= accept && !legal;
            if (issue) begin
                alu_x      <= rs1_data;
                alu_y      <= is_op ? rs2_data : imm;
                alu_funct3 <= funct3;
                alu_funct7 <= funct7_issue;
                alu_sel    <= !is_op;
                alu_rd     <= rd;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector table, reset-mid-stall sequence and randomized traffic against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        alu_valid;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic        alu_sel;
    logic [4:0]  alu_rd;
    logic        illegal_instr;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .alu_valid     (alu_valid),
        .alu_x         (alu_x),
        .alu_y         (alu_y),
        .alu_funct3    (alu_funct3),
        .alu_funct7    (alu_funct7),
        .alu_sel       (alu_sel),
        .alu_rd        (alu_rd),
        .illegal_instr (illegal_instr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input bit we,
                         input logic [4:0] wr, input logic [31:0] wd);
        instr_valid = v;
        instr       = w;
        wb_en       = we;
        wb_rd       = wr;
        wb_data     = wd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " alu_valid"}, {31'd0, alu_valid}, 32'd0);
        chk({tag, " illegal"},   {31'd0, illegal_instr}, 32'd0);
        chk({tag, " x"},         alu_x, 32'd0);
        chk({tag, " y"},         alu_y, 32'd0);
        chk({tag, " funct3"},    {29'd0, alu_funct3}, 32'd0);
        chk({tag, " funct7"},    {25'd0, alu_funct7}, 32'd0);
        chk({tag, " sel"},       {31'd0, alu_sel}, 32'd0);
        chk({tag, " rd"},        {27'd0, alu_rd}, 32'd0);
    endtask

    typedef struct {
        bit          valid;
        logic [31:0] instr;
        bit          wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        bit          e_ready;
        bit          e_valid;
        bit          e_illegal;
        logic [31:0] e_x;
        logic [31:0] e_y;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        bit          e_sel;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    function automatic void ref_decode(input logic [31:0] w, output bit legal, output bit is_op,
                                       output logic [31:0] imm, output logic [6:0] f7o);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op    = w[6:0];
        f3    = w[14:12];
        f7    = w[31:25];
        legal = 0;
        is_op = 0;
        f7o   = 7'd0;
        imm   = {{20{w[31]}}, w[31:20]};
        if (op == 7'h33) begin
            is_op = 1;
            f7o   = f7;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (op == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                imm   = {27'd0, w[24:20]};
                f7o   = f7;
                legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            end else begin
                legal = 1;
            end
        end
    endfunction

    function automatic logic [31:0] read_val(input logic [4:0] r, input bit we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  r1, r2, rdv;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm12;
        int          kind;
        r1    = 5'($urandom_range(0, 7));
        r2    = 5'($urandom_range(0, 7));
        rdv   = 5'($urandom_range(0, 7));
        f3    = 3'($urandom_range(0, 7));
        imm12 = 12'($urandom);
        kind  = $urandom_range(0, 9);
        if (kind <= 3) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {f7, r2, r1, f3, rdv, 7'h33};
        end else if (kind <= 7) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                if ($urandom_range(0, 5) == 0) f7 = 7'($urandom);
                return {f7, r2, r1, f3, rdv, 7'h13};
            end
            return {imm12, r1, f3, rdv, 7'h13};
        end else if (kind == 8) begin
            return {imm12, r1, f3, rdv, 7'($urandom)};
        end
        return {7'($urandom), r2, r1, f3, rdv, 7'h33};
    endfunction

    initial begin
        bit          cur_valid, stalled, legal, is_op, m_ready, acc, e_valid, e_ill;
        logic [31:0] cur_instr, imm, ex, ey;
        logic [6:0]  f7o;
        logic [4:0]  rs1, rs2, rdv;

        rst = 1'b1;
        drive(0, 32'd0, 0, 5'd0, 32'd0);

        // Directed rows: {valid, instr, wb_en, wb_rd, wb_data, ready, valid, illegal, x, y, f3, f7, sel, rd}
        tbl.push_back('{1, 32'hFFB00093, 0, 5'd0, 32'h0,    1, 1, 0, 32'h0,  32'hFFFFFFFB, 3'd0, 7'h00, 1, 5'd1});
        tbl.push_back('{1, 32'h00108133, 0, 5'd0, 32'h0,    0, 0, 0, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{1, 32'h00108133, 1, 5'd1, 32'h7,    1, 1, 0, 32'h7,  32'h7,        3'd0, 7'h00, 0, 5'd2});
        tbl.push_back('{1, 32'h40325193, 0, 5'd0, 32'h0,    1, 1, 0, 32'h0,  32'h3,        3'd5, 7'h20, 1, 5'd3});
        tbl.push_back('{1, 32'h40321193, 0, 5'd0, 32'h0,    1, 0, 1, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{1, 32'h00000333, 1, 5'd0, 32'hDEAD, 1, 1, 0, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd6});
        tbl.push_back('{1, 32'h00100293, 1, 5'd5, 32'h55,   1, 1, 0, 32'h0,  32'h1,        3'd0, 7'h00, 1, 5'd5});
        tbl.push_back('{1, 32'h000283B3, 0, 5'd0, 32'h0,    0, 0, 0, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{0, 32'h000283B3, 0, 5'd0, 32'h0,    1, 0, 0, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{1, 32'h0002A003, 0, 5'd0, 32'h0,    1, 0, 1, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{1, 32'h000283B3, 0, 5'd0, 32'h0,    0, 0, 0, 32'h0,  32'h0,        3'd0, 7'h00, 0, 5'd0});
        tbl.push_back('{1, 32'h000283B3, 1, 5'd5, 32'h99,   1, 1, 0, 32'h99, 32'h0,        3'd0, 7'h00, 0, 5'd7});

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset ready", {31'd0, instr_ready}, 32'd1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].instr, tbl[i].wb_en, tbl[i].wb_rd, tbl[i].wb_data);
            #1;
            chk($sformatf("row%0d ready", i), {31'd0, instr_ready}, {31'd0, tbl[i].e_ready});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d alu_valid", i), {31'd0, alu_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d illegal", i), {31'd0, illegal_instr}, {31'd0, tbl[i].e_illegal});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d x", i), alu_x, tbl[i].e_x);
                chk($sformatf("row%0d y", i), alu_y, tbl[i].e_y);
                chk($sformatf("row%0d funct3", i), {29'd0, alu_funct3}, {29'd0, tbl[i].e_f3});
                chk($sformatf("row%0d funct7", i), {25'd0, alu_funct7}, {25'd0, tbl[i].e_f7});
                chk($sformatf("row%0d sel", i), {31'd0, alu_sel}, {31'd0, tbl[i].e_sel});
                chk($sformatf("row%0d rd", i), {27'd0, alu_rd}, {27'd0, tbl[i].e_rd});
            end
        end

        // Reset in the middle of a stall: ADD x8,x7,x0 waits on x7.
        drive(1, 32'h00038433, 0, 5'd0, 32'h0);
        #1;
        chk("stall ready", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("stall alu_valid", {31'd0, alu_valid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midstall reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post-reset ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post-reset alu_valid", {31'd0, alu_valid}, 32'd1);
        chk("post-reset rd", {27'd0, alu_rd}, 32'd8);
        // x5 and x1 held 0x99 and 7 before reset; both must read back as 0.
        drive(1, 32'h001284B3, 0, 5'd0, 32'h0);
        #1;
        chk("regs-cleared ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("regs-cleared valid", {31'd0, alu_valid}, 32'd1);
        chk("regs-cleared x", alu_x, 32'd0);
        chk("regs-cleared y", alu_y, 32'd0);

        // Randomized traffic against the model, starting from a fresh reset.
        drive(0, 32'd0, 0, 5'd0, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        cur_valid = 0;
        cur_instr = 32'd0;
        stalled   = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stalled) begin
                if ($urandom_range(0, 9) == 0) cur_valid = 0;
            end else begin
                cur_valid = ($urandom_range(0, 4) != 0);
                cur_instr = gen_instr();
            end
            drive(cur_valid, cur_instr, ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), $urandom);

            ref_decode(cur_instr, legal, is_op, imm, f7o);
            rs1 = cur_instr[19:15];
            rs2 = cur_instr[24:20];
            rdv = cur_instr[11:7];
            m_ready = !(cur_valid && legal &&
                        ((rs1 != 0 && m_pend[rs1] && !(wb_en && wb_rd == rs1)) ||
                         (is_op && rs2 != 0 && m_pend[rs2] && !(wb_en && wb_rd == rs2))));
            acc     = cur_valid && m_ready;
            e_valid = acc && legal;
            e_ill   = acc && !legal;
            ex      = read_val(rs1, wb_en, wb_rd, wb_data);
            ey      = is_op ? read_val(rs2, wb_en, wb_rd, wb_data) : imm;

            #1;
            chk("rand ready", {31'd0, instr_ready}, {31'd0, m_ready});
            @(posedge clk);
            #1;
            chk("rand alu_valid", {31'd0, alu_valid}, {31'd0, e_valid});
            chk("rand illegal", {31'd0, illegal_instr}, {31'd0, e_ill});
            if (e_valid) begin
                chk("rand x", alu_x, ex);
                chk("rand y", alu_y, ey);
                chk("rand funct3", {29'd0, alu_funct3}, {29'd0, cur_instr[14:12]});
                chk("rand funct7", {25'd0, alu_funct7}, {25'd0, f7o});
                chk("rand sel", {31'd0, alu_sel}, {31'd0, !is_op});
                chk("rand rd", {27'd0, alu_rd}, {27'd0, rdv});
            end

            if (wb_en) begin
                if (wb_rd != 0) m_regs[wb_rd] = wb_data;
                m_pend[wb_rd] = 0;
            end
            if (e_valid && rdv != 0) m_pend[rdv] = 1;
            stalled = cur_valid && !m_ready;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
